pipe_issue: RTL and testbench
=============================

PIPE_ISSUE -- requirements
Module: pipe_issue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the instruction FIFO entry count; legal values are powers of two, 2..16.
REQ-002 The module SHALL have parameter LAT, default 3, giving the cycles from issue until the destination register write is visible; legal range is 1..8.
REQ-003 clk_1  input  1  The module SHALL run from this single clock, with all state updated on its rising edge.
REQ-004 rst_n  input  1  Reset is synchronous and active-low.
REQ-005 in_valid  input  1  Asserted, this SHALL indicate that in_instr holds an instruction offered for acceptance.
REQ-006 in_instr  input  22  The field packing SHALL be {func[1:0], RS_1[3:0], RS_2[3:0], RD[3:0], addr[7:0]}, MSB first.
REQ-007 in_ready  output  1  This SHALL indicate the FIFO can accept an instruction this cycle.
REQ-008 RS_1, RS_2, RD  output  4 each  These SHALL carry the register fields of the issued instruction to the pipeline.
REQ-009 func  output  2  This SHALL carry the operation code, passed through unmodified.
REQ-010 addr  output  8  This SHALL carry the result memory address, passed through unmodified.
REQ-011 issue_v  output  1  Asserted, this SHALL mark the field outputs as a new instruction this cycle; deasserted, the cycle SHALL be a bubble.
REQ-012 issue_cnt  output  16  This SHALL count issued instructions.
REQ-013 stall_cnt  output  16  This SHALL count hazard-stall cycles.

Function
REQ-014 An instruction SHALL be accepted on a rising edge exactly when in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL equal (occupancy < DEPTH), computed from registered occupancy only.
REQ-016 The FIFO SHALL be in-order, with read and write pointers that wrap modulo DEPTH.
REQ-017 A push and a pop in the same edge SHALL leave occupancy unchanged.
REQ-018 A push into a full FIFO cannot occur, because in_ready is low when full.
REQ-019 Every output SHALL be registered.
REQ-020 An instruction accepted at edge E SHALL be eligible to issue no earlier than the edge E+1.
REQ-021 Eligibility at E+1 SHALL give issue_v=1 in the cycle following E+1, which is a minimum latency of one cycle.
REQ-022 At each edge the FIFO head SHALL issue, and be popped, unless the FIFO is empty or a hazard exists.
REQ-023 Hazard definition: a hazard exists when head RS_1 or head RS_2 equals the RD of any instruction issued in one of the previous LAT-1 issue cycles.
REQ-024 Hazard timing: with the producer's issue_v high in cycle c, a dependent instruction SHALL have issue_v high no earlier than cycle c+LAT, and exactly at c+LAT if it is the head by then.
REQ-025 The hazard tracking SHALL be a scoreboard shift register of LAT-1 {valid, rd} entries that shifts every cycle, with bubbles inserting valid=0.
REQ-026 When LAT=1 the scoreboard SHALL be absent and hazards SHALL never occur.
REQ-027 A match on RD alone (a WAW case) SHALL NOT cause a stall.
REQ-028 Register 0 SHALL receive no special treatment.
REQ-029 During a bubble, RS_1, RS_2, RD, func and addr SHALL hold the last issued values, and issue_v SHALL be 0.
REQ-030 issue_cnt SHALL increment on every edge that issues an instruction.
REQ-031 stall_cnt SHALL increment on every edge where the FIFO is non-empty and the head is blocked by a hazard.
REQ-032 Both counters SHALL saturate at 0xFFFF.
REQ-033 An empty FIFO SHALL NOT count as a stall.
REQ-034 Issue is in order: a blocked head SHALL block every younger instruction.

Reset
REQ-035 An edge with rst_n=0 SHALL clear the FIFO occupancy and pointers.
REQ-036 The same edge SHALL clear all scoreboard valid bits.
REQ-037 The same edge SHALL force RS_1, RS_2, RD, func, addr, issue_v, issue_cnt and stall_cnt to 0.
REQ-038 in_ready SHALL be 1 in the cycle after the reset edge.
REQ-039 Instructions held or in flight at reset SHALL be discarded.
REQ-040 An in_valid presented during a reset edge SHALL NOT be accepted.

Verification
REQ-041 Reset check: hold rst_n=0 for 2 edges, then release -> all outputs are 0 and in_ready=1.
REQ-042 Independent stream (LAT=3): push back-to-back (5,3,1,00,125), (6,4,2,01,126), (7,5,3,00,127), (8,6,4,01,128), (9,7,5,00,129) -> issue_v high for 5 consecutive cycles in order, issue_cnt=5, stall_cnt=0.
REQ-043 RAW stall (LAT=3): push (5,3,RD=1) then (1,2,RD=6) -> second issue_v occurs exactly 3 cycles after the first, with 2 bubbles and stall_cnt=2.
REQ-044 FIFO full: push a chain of 6 instructions, each reading the previous RD, continuously -> in_ready falls after 4 are held and resumes as entries issue, all 6 issue in order with 3-cycle spacing, and none are lost or duplicated.
REQ-045 WAW no stall: push (2,3,RD=4) then (5,6,RD=4) -> issue in consecutive cycles, stall_cnt=0.
REQ-046 Mid-operation reset: assert rst_n=0 while 3 entries are held and the scoreboard is valid, then push (1,2,RD=3) -> it issues with no stall and issue_cnt=1.

Source files
------------

// File: rtl/pipe_issue_if.sv
// Instruction intake and issue bundle between the front end and pipe_issue.
// Master drives instructions in and observes issue; slave is the issue stage.
interface pipe_issue_if;
    logic        in_valid;
    logic [21:0] in_instr;
    logic        in_ready;
    logic [3:0]  RS_1;
    logic [3:0]  RS_2;
    logic [3:0]  RD;
    logic [1:0]  func;
    logic [7:0]  addr;
    logic        issue_v;
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;

    modport master (
        output in_valid, in_instr,
        input  in_ready, RS_1, RS_2, RD, func, addr, issue_v, issue_cnt, stall_cnt
    );

    modport slave (
        input  in_valid, in_instr,
        output in_ready, RS_1, RS_2, RD, func, addr, issue_v, issue_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_issue.sv
// In-order issue stage: instruction FIFO plus RAW scoreboard gating the head.
// Latency: accept at edge E, issue_v visible after edge E+1 at the earliest.
// Backpressure: in_ready drops when DEPTH entries are held; a RAW hazard stalls the head.
module pipe_issue #(
    parameter int DEPTH = 4,
    parameter int LAT   = 3
) (
    input  logic        clk_1,
    input  logic        rst_n,
    pipe_issue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [21:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ, occ_nxt;
    logic          ready_q;
    logic [21:0]   head;
    logic          push, pop, empty, hazard;

    logic [3:0]    rs1_q, rs2_q, rd_q;
    logic [1:0]    func_q;
    logic [7:0]    addr_q;
    logic          issue_q;
    logic [15:0]   issue_cnt_q, stall_cnt_q;

    assign head  = mem[rd_ptr];
    assign empty = (occ == '0);
    assign push  = bus.in_valid && ready_q;
    assign pop   = !empty && !hazard;

    always_comb begin
        occ_nxt = occ;
        if (push && !pop)
            occ_nxt = occ + 1'b1;
        else if (!push && pop)
            occ_nxt = occ - 1'b1;
    end

    always_ff @(posedge clk_1) begin
        if (rst_n && push)
            mem[wr_ptr] <= bus.in_instr;
    end

    // in_ready is registered from next occupancy so it reflects held entries only
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            occ     <= occ_nxt;
            ready_q <= (occ_nxt < (AW+1)'(DEPTH));
        end
    end

    // Slot i holds the instruction issued i+1 edges ago; bubbles shift in invalid
    generate
        if (LAT > 1) begin : g_sb
            logic [LAT-2:0] sb_vld;
            logic [3:0]     sb_rd [LAT-1];

            always_ff @(posedge clk_1) begin
                if (!rst_n) begin
                    sb_vld <= '0;
                end else begin
                    sb_vld[0] <= pop;
                    sb_rd[0]  <= head[11:8];
                    for (int i = 1; i < LAT-1; i++) begin
                        sb_vld[i] <= sb_vld[i-1];
                        sb_rd[i]  <= sb_rd[i-1];
                    end
                end
            end

            always_comb begin
                hazard = 1'b0;
                for (int i = 0; i < LAT-1; i++)
                    if (sb_vld[i] && (sb_rd[i] == head[19:16] || sb_rd[i] == head[15:12]))
                        hazard = 1'b1;
            end
        end else begin : g_no_sb
            assign hazard = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            func_q      <= '0;
            addr_q      <= '0;
            issue_q     <= 1'b0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_q <= pop;
            if (pop) begin
                func_q <= head[21:20];
                rs1_q  <= head[19:16];
                rs2_q  <= head[15:12];
                rd_q   <= head[11:8];
                addr_q <= head[7:0];
                if (issue_cnt_q != 16'hFFFF)
                    issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (!empty && hazard && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.RS_1      = rs1_q;
    assign bus.RS_2      = rs2_q;
    assign bus.RD        = rd_q;
    assign bus.func      = func_q;
    assign bus.addr      = addr_q;
    assign bus.issue_v   = issue_q;
    assign bus.issue_cnt = issue_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_issue.sv
// Directed bench for pipe_issue (DEPTH=4, LAT=3): reset, streams, RAW/WAW, full FIFO, mid-run reset.
module tb_pipe_issue;
    logic clk_1 = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_1 = ~clk_1;

    pipe_issue_if bus ();

    pipe_issue #(.DEPTH(4), .LAT(3)) dut (
        .clk_1 (clk_1),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int evc[$];
    logic [21:0] evi[$];

    always @(posedge clk_1) cyc <= cyc + 1;

    // Issue log: posedge count and {func,RS_1,RS_2,RD,addr} of every issued instruction
    always @(posedge clk_1) begin
        #1;
        if (bus.issue_v === 1'b1) begin
            evc.push_back(cyc);
            evi.push_back({bus.func, bus.RS_1, bus.RS_2, bus.RD, bus.addr});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [21:0] mk(input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [3:0] rd, input logic [1:0] f,
                                       input logic [7:0] a);
        return {f, rs1, rs2, rd, a};
    endfunction

    function automatic int ev_cyc(input int i);
        return (i < evc.size()) ? evc[i] : -1;
    endfunction

    function automatic logic [21:0] ev_ins(input int i);
        return (i < evi.size()) ? evi[i] : 22'h3FFFFF;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_1);
    endtask

    task automatic push(input logic [21:0] ins);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        for (int t = 0; t < 50 && !ok; t++) begin
            ok = (bus.in_ready === 1'b1);
            @(negedge clk_1);
        end
        bus.in_valid = 1'b0;
        chk("push_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk_1);
        rst_n = 1'b1;
        evc.delete();
        evi.delete();
    endtask

    initial begin
        logic [21:0] ins [6];
        logic [21:0] a, b, x;
        int k;

        // Reset with a valid instruction offered that must be ignored
        bus.in_valid = 1'b1;
        bus.in_instr = mk(4'd1, 4'd2, 4'd3, 2'd1, 8'hAA);
        repeat (2) @(negedge clk_1);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        evc.delete();
        evi.delete();
        chk("rst_issue_v", {31'd0, bus.issue_v}, 32'd0);
        chk("rst_fields", {10'd0, bus.func, bus.RS_1, bus.RS_2, bus.RD, bus.addr}, 32'd0);
        chk("rst_issue_cnt", {16'd0, bus.issue_cnt}, 32'd0);
        chk("rst_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        idle(4);
        chk("rst_no_accept_cnt", {16'd0, bus.issue_cnt}, 32'd0);
        chk("rst_no_accept_log", evc.size(), 32'd0);

        // Independent back-to-back stream
        ins[0] = mk(4'd5, 4'd3, 4'd1, 2'd0, 8'd125);
        ins[1] = mk(4'd6, 4'd4, 4'd2, 2'd1, 8'd126);
        ins[2] = mk(4'd7, 4'd5, 4'd3, 2'd0, 8'd127);
        ins[3] = mk(4'd8, 4'd6, 4'd4, 2'd1, 8'd128);
        ins[4] = mk(4'd9, 4'd7, 4'd5, 2'd0, 8'd129);
        k = cyc;
        for (int i = 0; i < 5; i++) push(ins[i]);
        idle(6);
        chk("ind_count", evc.size(), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("ind_instr%0d", i), {10'd0, ev_ins(i)}, {10'd0, ins[i]});
            chk($sformatf("ind_cycle%0d", i), ev_cyc(i), k + 2 + i);
        end
        chk("ind_issue_cnt", {16'd0, bus.issue_cnt}, 32'd5);
        chk("ind_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);

        // RAW: second reads RD=1 of the first
        do_reset(2);
        a = mk(4'd5, 4'd3, 4'd1, 2'd2, 8'h40);
        b = mk(4'd1, 4'd2, 4'd6, 2'd3, 8'h41);
        k = cyc;
        push(a);
        push(b);
        chk("raw_first_v", {31'd0, bus.issue_v}, 32'd1);
        chk("raw_first_rd", {28'd0, bus.RD}, 32'd1);
        idle(1);
        chk("raw_bubble_v", {31'd0, bus.issue_v}, 32'd0);
        chk("raw_bubble_hold", {10'd0, bus.func, bus.RS_1, bus.RS_2, bus.RD, bus.addr}, {10'd0, a});
        chk("raw_stall_mid", {16'd0, bus.stall_cnt}, 32'd1);
        idle(6);
        chk("raw_count", evc.size(), 32'd2);
        chk("raw_first_cycle", ev_cyc(0), k + 2);
        chk("raw_spacing", ev_cyc(1) - ev_cyc(0), 32'd3);
        chk("raw_second", {10'd0, ev_ins(1)}, {10'd0, b});
        chk("raw_stall_cnt", {16'd0, bus.stall_cnt}, 32'd2);
        chk("raw_issue_cnt", {16'd0, bus.issue_cnt}, 32'd2);

        // Dependent chain of 6 fills the FIFO
        do_reset(2);
        for (int i = 0; i < 6; i++) ins[i] = mk(4'(i), 4'd15, 4'(i + 1), 2'(i), 8'(16 * i));
        k = cyc;
        for (int i = 0; i < 6; i++) push(ins[i]);
        chk("full_ready_low", {31'd0, bus.in_ready}, 32'd0);
        idle(3);
        chk("full_ready_back", {31'd0, bus.in_ready}, 32'd1);
        idle(12);
        chk("full_count", evc.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("full_instr%0d", i), {10'd0, ev_ins(i)}, {10'd0, ins[i]});
            chk($sformatf("full_cycle%0d", i), ev_cyc(i), k + 2 + 3 * i);
        end
        chk("full_issue_cnt", {16'd0, bus.issue_cnt}, 32'd6);
        chk("full_stall_cnt", {16'd0, bus.stall_cnt}, 32'd10);

        // WAW only: same RD, no source overlap
        do_reset(2);
        a = mk(4'd2, 4'd3, 4'd4, 2'd1, 8'h10);
        b = mk(4'd5, 4'd6, 4'd4, 2'd2, 8'h20);
        push(a);
        push(b);
        idle(4);
        chk("waw_count", evc.size(), 32'd2);
        chk("waw_spacing", ev_cyc(1) - ev_cyc(0), 32'd1);
        chk("waw_second", {10'd0, ev_ins(1)}, {10'd0, b});
        chk("waw_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);

        // Reset while entries are held and the scoreboard holds RD=1
        do_reset(2);
        push(mk(4'd0, 4'd0, 4'd1, 2'd0, 8'h01));
        push(mk(4'd1, 4'd1, 4'd2, 2'd0, 8'h02));
        push(mk(4'd2, 4'd2, 4'd3, 2'd0, 8'h03));
        push(mk(4'd3, 4'd3, 4'd4, 2'd0, 8'h04));
        chk("mid_pre_issue_cnt", {16'd0, bus.issue_cnt}, 32'd1);
        chk("mid_pre_stall_cnt", {16'd0, bus.stall_cnt}, 32'd2);
        do_reset(1);
        x = mk(4'd1, 4'd2, 4'd3, 2'd3, 8'h77);
        k = cyc;
        push(x);
        idle(4);
        chk("mid_count", evc.size(), 32'd1);
        chk("mid_instr", {10'd0, ev_ins(0)}, {10'd0, x});
        chk("mid_cycle", ev_cyc(0), k + 2);
        chk("mid_issue_cnt", {16'd0, bus.issue_cnt}, 32'd1);
        chk("mid_stall_cnt", {16'd0, bus.stall_cnt}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
